lut_sweep_unit: RTL and testbench
=================================

# lut_sweep_unit

Parametrised, registered truth-table engine that generalises the team's fixed 3-input/3-output combinational circuits to an IN_W-input, OUT_W-output function. The function is held in a runtime-programmable table. It adds a built-in exhaustive sweep that walks every input combination, the same way our combinational benches do, and accumulates an output signature. It sits between the stimulus/config logic and downstream consumers as a drop-in, self-checking replacement for hard-wired logic blocks.

## Interface
- IN_W, 3, input width; table depth is 2^IN_W; legal 1..8
- OUT_W, 3, output width; legal 1..32
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  IN_W  table entry to write
- cfg_data  in  OUT_W  value written
- in_valid  in  1  lookup request
- in_data  in  IN_W  lookup input combination
- sweep_start  in  1  start exhaustive sweep (sampled in IDLE only)
- out_valid  out  1  out_data/out_addr valid this cycle
- out_addr  out  IN_W  input combination that produced out_data
- out_data  out  OUT_W  table[out_addr]
- sweep_busy  out  1  high in SWEEP and FLUSH
- sweep_done  out  1  one-cycle pulse with the last sweep output
- sweep_sig  out  OUT_W  sweep signature; held until the next sweep starts
- cfg_err  out  1  one-cycle pulse when cfg_we arrives while busy

## Operation
- Reset: every table entry is 0; FSM goes to IDLE, counter 0. All outputs are 0: out_valid, out_addr, out_data, sweep_busy, sweep_done, sweep_sig, cfg_err.
- FSM states:
  - IDLE: sweep_start goes to SWEEP, clears counter and signature.
  - SWEEP: counter increments by 1 per cycle; at counter = 2^IN_W-1 goes to FLUSH.
  - FLUSH: lasts one cycle, asserts sweep_done, then returns to IDLE.
- Lookup, IDLE only: in_valid registers out_valid=1, out_addr=in_data, out_data=table[in_data]. in_valid is ignored in SWEEP and FLUSH.
- Sweep: each SWEEP cycle addresses table[counter]; the result is registered exactly like a lookup.
- Signature: on every sweep output, sig = rotl1(sig) XOR out_data, computed over OUT_W bits. Lookups never update sig.
- Config writes:
  - cfg_we in IDLE writes the table at the clock edge.
  - cfg_we in SWEEP or FLUSH is dropped and cfg_err pulses the next cycle.
- Simultaneous events:
  - cfg_we and in_valid to the same address in the same cycle: the lookup returns the old value (read-before-write).
  - sweep_start and in_valid in the same IDLE cycle: the sweep wins and the lookup is dropped.
  - sweep_start while busy is ignored.
- Counter wrap: the counter is IN_W bits; the terminal value 2^IN_W-1 ends the sweep, so no out-of-range address is ever generated.
- Reset mid-sweep: immediate return to the reset state; any partial signature is lost and the table is cleared.

## Timing
- Lookup latency: 1 cycle. Request at edge T gives out_valid in cycle T+1. Back-to-back lookups run at full throughput.
- Sweep:
  - sweep_start sampled at T; sweep_busy high from T+1 through T+1+2^IN_W.
  - Output for address k appears at T+2+k.
  - The last output (k = 2^IN_W-1) and the sweep_done pulse appear together at T+1+2^IN_W.
  - sweep_sig is final in that same cycle.
  - IDLE at T+2+2^IN_W; a new sweep_start is accepted from that cycle.
- out_valid is 0 in any cycle with no lookup and no sweep output.
- cfg_err asserts one cycle after the rejected write.

## Configuration
- LUT_SWEEP_SIG_EN defined: signature logic present as described.
- LUT_SWEEP_SIG_EN undefined: no signature register; sweep_sig is tied to 0. The sweep still runs and still produces out_valid and sweep_done.

## Structure
- Shared package lut_sweep_pkg holds:
  - the FSM state enum (IDLE, SWEEP, FLUSH);
  - the rotl1 signature function;
  - default constants IN_W_DEF=3, OUT_W_DEF=3.
- One sub-module, lut_sweep_table: a 2^IN_W x OUT_W register array with async-clear, one write port and one read port with registered output. The FSM, counter and signature stay in the top level.

## Test plan
All scenarios use IN_W=3, OUT_W=3.
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately; lookup in_data=5 after release -> out_data=0.
- Program table[i]=~i for i=0..7, then lookup in_data=3'b101 -> out_valid=1, out_addr=5, out_data=3'b010 one cycle later.
- Same program, sweep_start at T:
  - out_data 7,6,5,4,3,2,1,0 at T+2..T+9;
  - sweep_done pulses at T+9;
  - sweep_sig=3'b110 (with LUT_SWEEP_SIG_EN).
- Same-cycle cfg_we (addr 2, data 3'b111) and in_valid (in_data 2) -> out_data=3'b101 (old value); a following lookup returns 3'b111.
- During a sweep: cfg_we -> table unchanged, cfg_err pulses once; sweep_start -> ignored, exactly 8 outputs produced.
- rst_n pulled low at T+5 of a sweep -> sweep_busy=0 and sweep_sig=0 immediately; no sweep_done; a new sweep starts cleanly after release.

Source files
------------

// File: rtl/lut_sweep_pkg.sv
// Shared types and helpers for the lut_sweep_unit truth-table engine.
// Holds the sweep FSM state encoding, default widths and the signature rotate.
package lut_sweep_pkg;

    localparam int IN_W_DEF  = 3;
    localparam int OUT_W_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Rotate left by one inside the low w bits; bits above w must already be zero.
    function automatic logic [31:0] rotl1(input logic [31:0] v, input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/lut_sweep_if.sv
// Bus bundle for lut_sweep_unit: config writes, lookups, sweep control and results.
// master = stimulus/config side, slave = the lookup engine.
interface lut_sweep_if #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 3
);
    // Handshake: in_valid/cfg_we/sweep_start are single-cycle requests with no
    // ready; out_valid marks a result for exactly one cycle and is never stalled.
    logic             cfg_we;
    logic [IN_W-1:0]  cfg_addr;
    logic [OUT_W-1:0] cfg_data;
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             sweep_start;
    logic             out_valid;
    logic [IN_W-1:0]  out_addr;
    logic [OUT_W-1:0] out_data;
    logic             sweep_busy;
    logic             sweep_done;
    logic [OUT_W-1:0] sweep_sig;
    logic             cfg_err;

    modport master (
        output cfg_we, cfg_addr, cfg_data, in_valid, in_data, sweep_start,
        input  out_valid, out_addr, out_data, sweep_busy, sweep_done, sweep_sig, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, in_valid, in_data, sweep_start,
        output out_valid, out_addr, out_data, sweep_busy, sweep_done, sweep_sig, cfg_err
    );
endinterface

// File: rtl/lut_sweep_unit_table.sv
// 2^IN_W x OUT_W table with async clear, one write port and a registered read port.
// o_peek is the unregistered read of the same address, used for the sweep signature.
module lut_sweep_table #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [IN_W-1:0]  i_waddr,
    input  logic [OUT_W-1:0] i_wdata,
    input  logic             i_rd_en,
    input  logic [IN_W-1:0]  i_rd_addr,
    output logic             o_rd_valid,
    output logic [IN_W-1:0]  o_rd_addr,
    output logic [OUT_W-1:0] o_rd_data,
    output logic [OUT_W-1:0] o_peek
);
    localparam int DEPTH = 1 << IN_W;

    logic [OUT_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read samples the array before the same-edge write lands: read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rd_valid <= 1'b0;
            o_rd_addr  <= '0;
            o_rd_data  <= '0;
        end else begin
            o_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                o_rd_addr <= i_rd_addr;
                o_rd_data <= r_mem[i_rd_addr];
            end
        end
    end

    assign o_peek = r_mem[i_rd_addr];

endmodule

// File: rtl/lut_sweep_unit.sv
// Programmable truth-table engine with an exhaustive self-sweep and output signature.
// Define LUT_SWEEP_SIG_EN to build the signature register; otherwise sweep_sig is 0.
module lut_sweep_unit
    import lut_sweep_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    lut_sweep_if.slave   bus,
    output state_e       o_state
);
    localparam logic [IN_W-1:0] CNT_MAX = '1;

    state_e           r_state;
    logic [IN_W-1:0]  r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic             w_idle;
    logic             w_sweep;
    logic             w_start;
    logic             w_we;
    logic             w_rd_en;
    logic [IN_W-1:0]  w_rd_addr;
    logic [OUT_W-1:0] w_peek;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_sweep   = (r_state == ST_SWEEP);
    assign w_start   = w_idle && bus.sweep_start;
    assign w_we      = w_idle && bus.cfg_we;
    // A starting sweep takes priority over a lookup in the same cycle.
    assign w_rd_en   = w_sweep || (w_idle && bus.in_valid && !bus.sweep_start);
    assign w_rd_addr = w_sweep ? r_cnt : bus.in_data;

    lut_sweep_table #(.IN_W(IN_W), .OUT_W(OUT_W)) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_we),
        .i_waddr    (bus.cfg_addr),
        .i_wdata    (bus.cfg_data),
        .i_rd_en    (w_rd_en),
        .i_rd_addr  (w_rd_addr),
        .o_rd_valid (bus.out_valid),
        .o_rd_addr  (bus.out_addr),
        .o_rd_data  (bus.out_data),
        .o_peek     (w_peek)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= bus.cfg_we && !w_idle;
            case (r_state)
                ST_IDLE: begin
                    if (bus.sweep_start) begin
                        r_state <= ST_SWEEP;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    r_cnt <= r_cnt + 1'b1;
                    // done is registered alongside the last table read
                    if (r_cnt == CNT_MAX) begin
                        r_state <= ST_FLUSH;
                        r_done  <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef LUT_SWEEP_SIG_EN
    logic [OUT_W-1:0] r_sig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (w_start) begin
            r_sig <= '0;
        end else if (w_sweep) begin
            r_sig <= OUT_W'(rotl1(32'(r_sig), OUT_W)) ^ w_peek;
        end
    end

    assign bus.sweep_sig = r_sig;
`else
    logic w_unused_peek;
    assign w_unused_peek = ^w_peek;
    assign bus.sweep_sig = '0;
`endif

    assign bus.sweep_busy = r_busy;
    assign bus.sweep_done = r_done;
    assign bus.cfg_err    = r_err;
    assign o_state        = r_state;

endmodule

// File: tb/tb_lut_sweep_unit.sv
// Self-checking bench for lut_sweep_unit (IN_W=3, OUT_W=3) against a table/queue model.
// Honours LUT_SWEEP_SIG_EN when computing the expected signature.
module tb_lut_sweep_unit;
    import lut_sweep_pkg::*;

    localparam int IN_W  = 3;
    localparam int OUT_W = 3;
`ifdef LUT_SWEEP_SIG_EN
    localparam bit SIG_EN = 1'b1;
`else
    localparam bit SIG_EN = 1'b0;
`endif

    logic   clk;
    logic   rst_n;
    state_e dbg_state;

    lut_sweep_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    lut_sweep_unit #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .o_state (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [OUT_W-1:0] model_tbl [8];
    logic [OUT_W-1:0] exp_q [$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        bus.cfg_we      = 1'b0;
        bus.cfg_addr    = '0;
        bus.cfg_data    = '0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.sweep_start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model_tbl[i] = '0;
    endtask

    task automatic write_entry(input logic [IN_W-1:0] a, input logic [OUT_W-1:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_data = d;
        tick();
        bus.cfg_we   = 1'b0;
        model_tbl[a] = d;
    endtask

    task automatic program_inverse();
        for (int i = 0; i < 8; i++) write_entry(IN_W'(i), ~OUT_W'(i));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        clear_model();
        repeat (2) tick();
        n_tests++;
        if ({bus.out_valid, bus.out_addr, bus.out_data, bus.sweep_busy, bus.sweep_done,
             bus.sweep_sig, bus.cfg_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b a=%0d d=%0d busy=%b done=%b sig=%0d err=%b expected all 0",
                     bus.out_valid, bus.out_addr, bus.out_data, bus.sweep_busy, bus.sweep_done,
                     bus.sweep_sig, bus.cfg_err);
        end
        rst_n = 1'b1;
        tick();
        write_entry(3'd5, 3'd3);
        bus.in_valid = 1'b1; bus.in_data = 3'd5;
        tick();
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 3'd3) begin
            n_fail++;
            $display("FAIL reset_prelookup: got v=%b d=%0d expected v=1 d=3", bus.out_valid, bus.out_data);
        end
        // async reset asserted mid-cycle
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        clear_model();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 3'd0 || bus.out_addr !== 3'd0 ||
            bus.sweep_busy !== 1'b0 || bus.sweep_sig !== 3'd0 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_async: got v=%b a=%0d d=%0d busy=%b sig=%0d st=%0d expected all 0",
                     bus.out_valid, bus.out_addr, bus.out_data, bus.sweep_busy, bus.sweep_sig, dbg_state);
        end
        tick();
        rst_n = 1'b1;
        tick();
        bus.in_valid = 1'b1; bus.in_data = 3'd5;
        tick();
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_table_cleared: got v=%b d=%0d expected v=1 d=0", bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_lookup();
        program_inverse();
        bus.in_valid = 1'b1; bus.in_data = 3'b101;
        tick();
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_addr !== 3'd5 || bus.out_data !== 3'b010) begin
            n_fail++;
            $display("FAIL lookup_5: got v=%b a=%0d d=%b expected v=1 a=5 d=010",
                     bus.out_valid, bus.out_addr, bus.out_data);
        end
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lookup_idle_valid: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_read_before_write();
        program_inverse();
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd2; bus.cfg_data = 3'b111;
        bus.in_valid = 1'b1; bus.in_data = 3'd2;
        tick();
        bus.cfg_we = 1'b0;
        n_tests++;
        if (bus.out_data !== model_tbl[2] || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rbw_old: got v=%b d=%b expected v=1 d=%b", bus.out_valid, bus.out_data, model_tbl[2]);
        end
        model_tbl[2] = 3'b111;
        tick();
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_data !== 3'b111) begin
            n_fail++;
            $display("FAIL rbw_new: got %b expected 111", bus.out_data);
        end
    endtask

    task automatic test_back_to_back();
        logic             we, lv;
        logic [IN_W-1:0]  wa, la;
        logic [OUT_W-1:0] wd;
        for (int it = 0; it < 48; it++) begin
            we = 1'($urandom_range(0, 1));
            lv = ($urandom_range(0, 3) != 0);
            wa = IN_W'($urandom_range(0, 7));
            la = IN_W'($urandom_range(0, 7));
            wd = OUT_W'($urandom_range(0, 7));
            bus.cfg_we = we; bus.cfg_addr = wa; bus.cfg_data = wd;
            bus.in_valid = lv; bus.in_data = la;
            exp_q.push_back(model_tbl[la]);
            tick();
            n_tests++;
            if (bus.out_valid !== lv || bus.cfg_err !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_valid[%0d]: got v=%b err=%b expected v=%b err=0", it, bus.out_valid, bus.cfg_err, lv);
            end
            if (lv) begin
                n_tests++;
                if (bus.out_addr !== la || bus.out_data !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: got a=%0d d=%0d expected a=%0d d=%0d",
                             it, bus.out_addr, bus.out_data, la, exp_q[0]);
                end
            end
            void'(exp_q.pop_front());
            if (we) model_tbl[wa] = wd;
        end
        idle_inputs();
    endtask

    // Sweep from IDLE; with inject, also throws ignored lookups, a rejected write
    // and a second sweep_start at the engine while it is busy.
    task automatic test_sweep(input bit inject);
        logic [OUT_W-1:0] sig_m;
        logic [IN_W-1:0]  bad_a;
        int err_cnt, nvalid;
        sig_m = '0;
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(model_tbl[k]);
            sig_m = {sig_m[1:0], sig_m[2]} ^ model_tbl[k];
        end
        bad_a = IN_W'($urandom_range(0, 7));
        bus.sweep_start = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_data     = IN_W'($urandom_range(0, 7));
        tick();
        idle_inputs();
        n_tests++;
        if (bus.sweep_busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.sweep_sig !== 3'd0) begin
            n_fail++;
            $display("FAIL sweep_start: got busy=%b v=%b sig=%0d expected busy=1 v=0 sig=0",
                     bus.sweep_busy, bus.out_valid, bus.sweep_sig);
        end
        err_cnt = 0;
        nvalid  = 0;
        for (int cyc = 0; cyc < 9; cyc++) begin
            if (inject) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_data  = IN_W'($urandom_range(0, 7));
                bus.cfg_we   = (cyc == 2);
                bus.cfg_addr = bad_a;
                bus.cfg_data = ~model_tbl[bad_a];
                bus.sweep_start = (cyc == 4);
            end
            tick();
            idle_inputs();
            if (bus.cfg_err === 1'b1) err_cnt++;
            if (bus.out_valid === 1'b1) nvalid++;
            if (cyc < 8) begin
                n_tests++;
                if (bus.out_valid !== 1'b1 || bus.out_addr !== IN_W'(cyc) || bus.out_data !== exp_q[0] ||
                    bus.sweep_done !== (cyc == 7) || bus.sweep_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sweep_out[%0d]: got v=%b a=%0d d=%0d done=%b busy=%b expected v=1 a=%0d d=%0d done=%b busy=1",
                             cyc, bus.out_valid, bus.out_addr, bus.out_data, bus.sweep_done, bus.sweep_busy,
                             cyc, exp_q[0], (cyc == 7));
                end
                void'(exp_q.pop_front());
            end else begin
                n_tests++;
                if (bus.sweep_busy !== 1'b0 || bus.sweep_done !== 1'b0 || bus.out_valid !== 1'b0 ||
                    dbg_state !== ST_IDLE) begin
                    n_fail++;
                    $display("FAIL sweep_end: got busy=%b done=%b v=%b st=%0d expected idle",
                             bus.sweep_busy, bus.sweep_done, bus.out_valid, dbg_state);
                end
            end
            if (cyc == 7) begin
                n_tests++;
                if (bus.sweep_sig !== (SIG_EN ? sig_m : 3'd0)) begin
                    n_fail++;
                    $display("FAIL sweep_sig: got %b expected %b", bus.sweep_sig, (SIG_EN ? sig_m : 3'd0));
                end
            end
        end
        n_tests++;
        if (nvalid !== 8 || err_cnt !== (inject ? 1 : 0) || bus.sweep_sig !== (SIG_EN ? sig_m : 3'd0)) begin
            n_fail++;
            $display("FAIL sweep_counts: got outputs=%0d errs=%0d sig=%b expected outputs=8 errs=%0d sig=%b",
                     nvalid, err_cnt, bus.sweep_sig, (inject ? 1 : 0), (SIG_EN ? sig_m : 3'd0));
        end
        bus.in_valid = 1'b1; bus.in_data = bad_a;
        tick();
        idle_inputs();
        n_tests++;
        if (bus.out_data !== model_tbl[bad_a]) begin
            n_fail++;
            $display("FAIL sweep_table_kept: got %0d expected %0d", bus.out_data, model_tbl[bad_a]);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int done_seen;
        for (int i = 0; i < 8; i++) write_entry(IN_W'(i), OUT_W'($urandom_range(1, 7)));
        bus.sweep_start = 1'b1;
        tick();
        bus.sweep_start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        clear_model();
        n_tests++;
        if (bus.sweep_busy !== 1'b0 || bus.sweep_sig !== 3'd0 || bus.out_valid !== 1'b0 ||
            dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL midsweep_reset: got busy=%b sig=%0d v=%b st=%0d expected 0",
                     bus.sweep_busy, bus.sweep_sig, bus.out_valid, dbg_state);
        end
        tick();
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.sweep_done === 1'b1 || bus.sweep_busy === 1'b1) done_seen++;
        end
        n_tests++;
        if (done_seen !== 0) begin
            n_fail++;
            $display("FAIL midsweep_no_done: got %0d busy/done cycles expected 0", done_seen);
        end
        for (int i = 0; i < 8; i++) write_entry(IN_W'(i), OUT_W'($urandom_range(0, 7)));
        test_sweep(1'b0);
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_lookup();
        test_read_before_write();
        test_back_to_back();
        program_inverse();
        test_sweep(1'b0);
        for (int i = 0; i < 8; i++) write_entry(IN_W'(i), OUT_W'($urandom_range(0, 7)));
        test_sweep(1'b1);
        test_sweep(1'b1);
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
